// File: rtl/block_store_multi_pkg.sv
// Shared definitions for the multi-slot block store (package blkstore_pkg).
package blkstore_pkg;

  localparam int unsigned BLK_STATE_W_DEF = 352;

  typedef logic [BLK_STATE_W_DEF-1:0] blk_state_t;

  // Number of input beats that make up one assembled block.
  function automatic int unsigned beats_f(input int unsigned state_w, input int unsigned in_w);
    return state_w / in_w;
  endfunction

  // Ring pointer width; a single-slot ring still gets a 1-bit pointer.
  function automatic int unsigned ptr_w_f(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/block_store_multi_if.sv
// Host write port / hash-core read port bundle for block_store_multi.
// BLKSTORE_CNT_EN adds the blockCount status output.
interface block_store_multi_if #(
  parameter int unsigned IN_W    = 32,
  parameter int unsigned STATE_W = 352
);
  logic               writeValid;
  logic [IN_W-1:0]    blockData;
  logic               writeAbort;
  logic               writeReady;
  logic               readConsume;
  logic               validOut;
  logic               newBlock;
  logic [STATE_W-1:0] initialState;
  logic               overflow;
`ifdef BLKSTORE_CNT_EN
  logic [31:0]        blockCount;

  modport master (
    output writeValid, blockData, writeAbort, readConsume,
    input  writeReady, validOut, newBlock, initialState, overflow, blockCount
  );

  modport slave (
    input  writeValid, blockData, writeAbort, readConsume,
    output writeReady, validOut, newBlock, initialState, overflow, blockCount
  );
`else
  modport master (
    output writeValid, blockData, writeAbort, readConsume,
    input  writeReady, validOut, newBlock, initialState, overflow
  );

  modport slave (
    input  writeValid, blockData, writeAbort, readConsume,
    output writeReady, validOut, newBlock, initialState, overflow
  );
`endif
endinterface

// File: rtl/block_store_multi_assembler.sv
// Beat assembler: tracks the beat position within the block being loaded,
// handles abort, and produces the updated contents of the slot being written.
module blk_beat_assembler
  import blkstore_pkg::*;
#(
  parameter int unsigned IN_W    = 32,
  parameter int unsigned STATE_W = 352
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               write_valid,
  input  logic               write_ready,
  input  logic               write_abort,
  input  logic [IN_W-1:0]    block_data,
  input  logic [STATE_W-1:0] cur_blk,
  output logic               wr_en,
  output logic [STATE_W-1:0] nxt_blk,
  output logic               block_done
);
  localparam int unsigned BEATS  = beats_f(STATE_W, IN_W);
  localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  logic [BEAT_W-1:0] beat_q, beat_d;
  logic              accept;

  // Accept/abort decode, beat advance and merge of the beat into the slot image.
  always_comb begin
    accept     = write_valid && write_ready && !write_abort;
    wr_en      = accept;
    block_done = accept && (beat_q == BEAT_W'(BEATS - 1));
    nxt_blk    = cur_blk;
    beat_d     = beat_q;
    if (write_abort) begin
      beat_d = '0;
    end else if (accept) begin
      beat_d = block_done ? '0 : beat_q + BEAT_W'(1);
    end
    if (accept) begin
      for (int unsigned i = 0; i < BEATS; i++) begin
        if (beat_q == BEAT_W'(i)) begin
          nxt_blk[STATE_W-1-i*IN_W -: IN_W] = block_data;
        end
      end
    end
  end

  // Beat position register.
  always_ff @(posedge clk) begin
    if (rst) beat_q <= '0;
    else     beat_q <= beat_d;
  end

endmodule

// File: rtl/block_store_multi.sv
// Multi-slot block store: assembles IN_W-bit header beats into STATE_W-bit
// blocks and holds up to DEPTH complete blocks in a ring feeding the hash core.
// Optional feature macro: BLKSTORE_CNT_EN (adds blockCount).
module block_store_multi
  import blkstore_pkg::*;
#(
  parameter int unsigned IN_W    = 32,
  parameter int unsigned STATE_W = 352,
  parameter int unsigned DEPTH   = 2
) (
  input  logic              clk,
  input  logic              rst,
  block_store_multi_if.slave bus
);
  localparam int unsigned BEATS = beats_f(STATE_W, IN_W);
  localparam int unsigned PTR_W = ptr_w_f(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  if (BEATS * IN_W != STATE_W) begin : g_bad_width
    $error("block_store_multi: STATE_W must be a multiple of IN_W");
  end
  if (DEPTH < 1) begin : g_bad_depth
    $error("block_store_multi: DEPTH must be at least 1");
  end

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  logic [STATE_W-1:0] slot_q [DEPTH];
  logic [STATE_W-1:0] slot_d [DEPTH];
  logic [PTR_W-1:0]   wp_q, wp_d, rp_q, rp_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               valid_q, valid_d;
  logic               new_block_q, new_block_d;
  logic [STATE_W-1:0] init_state_q, init_state_d;
  logic               overflow_q, overflow_d;

  logic               write_ready;
  logic               rd_fire;
  logic               drop;
  logic               wr_en;
  logic               block_done;
  logic [STATE_W-1:0] nxt_blk;

  assign write_ready = (count_q < CNT_W'(DEPTH));

  blk_beat_assembler #(
    .IN_W    (IN_W),
    .STATE_W (STATE_W)
  ) u_asm (
    .clk         (clk),
    .rst         (rst),
    .write_valid (bus.writeValid),
    .write_ready (write_ready),
    .write_abort (bus.writeAbort),
    .block_data  (bus.blockData),
    .cur_blk     (slot_q[wp_q]),
    .wr_en       (wr_en),
    .nxt_blk     (nxt_blk),
    .block_done  (block_done)
  );

  // Ring bookkeeping and next-cycle read-side outputs. The head image is taken
  // from the post-write slot array so a just-completed block is visible at once.
  always_comb begin
    slot_d       = slot_q;
    wp_d         = wp_q;
    rp_d         = rp_q;
    count_d      = count_q;
    rd_fire      = bus.readConsume && valid_q;
    drop         = bus.writeValid && !write_ready && !bus.writeAbort;
    overflow_d   = overflow_q || drop;

    if (wr_en) slot_d[wp_q] = nxt_blk;
    if (block_done) wp_d = ptr_inc(wp_q);
    if (rd_fire) rp_d = ptr_inc(rp_q);

    unique case ({block_done, rd_fire})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    valid_d      = (count_d != '0);
    new_block_d  = valid_d && (rd_fire || (count_q == '0));
    init_state_d = valid_d ? slot_d[rp_d] : '0;
  end

  // Slot storage, pointers, count and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) slot_q[i] <= '0;
      wp_q         <= '0;
      rp_q         <= '0;
      count_q      <= '0;
      valid_q      <= 1'b0;
      new_block_q  <= 1'b0;
      init_state_q <= '0;
      overflow_q   <= 1'b0;
    end else begin
      slot_q       <= slot_d;
      wp_q         <= wp_d;
      rp_q         <= rp_d;
      count_q      <= count_d;
      valid_q      <= valid_d;
      new_block_q  <= new_block_d;
      init_state_q <= init_state_d;
      overflow_q   <= overflow_d;
    end
  end

  assign bus.writeReady   = write_ready;
  assign bus.validOut     = valid_q;
  assign bus.newBlock     = new_block_q;
  assign bus.initialState = init_state_q;
  assign bus.overflow     = overflow_q;

`ifdef BLKSTORE_CNT_EN
  logic [31:0] block_count_q, block_count_d;

  // Completed-block counter; wraps naturally at 2^32.
  always_comb begin
    block_count_d = block_count_q + (block_done ? 32'd1 : 32'd0);
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) block_count_q <= '0;
    else     block_count_q <= block_count_d;
  end

  assign bus.blockCount = block_count_q;
`endif

endmodule

// File: tb/tb_block_store_multi.sv
// Directed bench for block_store_multi (IN_W=32, STATE_W=352, DEPTH=2).
module tb_block_store_multi;
  import blkstore_pkg::*;

  localparam int unsigned IN_W    = 32;
  localparam int unsigned STATE_W = 352;
  localparam int unsigned DEPTH   = 2;
  localparam int unsigned BEATS   = 11;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  block_store_multi_if #(.IN_W(IN_W), .STATE_W(STATE_W)) bus ();

  block_store_multi #(
    .IN_W    (IN_W),
    .STATE_W (STATE_W),
    .DEPTH   (DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  typedef struct {
    logic        r, wv, ab, rc;
    logic [31:0] d;
    logic        ev, en, er, eo;
    logic [31:0] etop, ebot;
  } vec_t;

  vec_t tbl[$];

  function automatic void push(input logic r, input logic wv, input logic ab, input logic rc,
                               input logic [31:0] d, input logic ev, input logic en,
                               input logic er, input logic eo,
                               input logic [31:0] etop, input logic [31:0] ebot);
    vec_t v;
    v.r = r; v.wv = wv; v.ab = ab; v.rc = rc; v.d = d;
    v.ev = ev; v.en = en; v.er = er; v.eo = eo; v.etop = etop; v.ebot = ebot;
    tbl.push_back(v);
  endfunction

  function automatic blk_state_t mk_blk(input logic [31:0] base, input bit incr);
    blk_state_t b;
    b = '0;
    for (int unsigned i = 0; i < BEATS; i++)
      b[STATE_W-1-i*IN_W -: IN_W] = incr ? base + 32'(i) : base;
    return b;
  endfunction

  task automatic drive(input logic r, input logic wv, input logic [31:0] d,
                       input logic ab, input logic rc);
    rst              = r;
    bus.writeValid   = wv;
    bus.blockData    = d;
    bus.writeAbort   = ab;
    bus.readConsume  = rc;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic send(input logic [31:0] base, input bit incr, input int unsigned n);
    for (int unsigned i = 0; i < n; i++)
      drive(1'b0, 1'b1, incr ? base + 32'(i) : base, 1'b0, 1'b0);
  endtask

  task automatic chk1(input string nm, input logic a, input logic e);
    n_vec++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %0b want %0b", nm, a, e);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_vec++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, a, e);
    end
  endtask

  task automatic chk_blk(input string nm, input blk_state_t a, input blk_state_t e);
    n_vec++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, a, e);
    end
  endtask

  task automatic chk_out(input string tag, input logic ev, input logic en, input logic er,
                         input logic eo, input blk_state_t ei);
    chk1({tag, "/validOut"}, bus.validOut, ev);
    chk1({tag, "/newBlock"}, bus.newBlock, en);
    chk1({tag, "/writeReady"}, bus.writeReady, er);
    chk1({tag, "/overflow"}, bus.overflow, eo);
    chk_blk({tag, "/initialState"}, bus.initialState, ei);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    blk_state_t a_blk, b_blk, c_blk;

    // Scenario 1: reset, one block of beats 1..11, hold, consume, consume-while-empty.
    push(1, 0, 0, 0, 32'h0, 0, 0, 1, 0, 32'h0, 32'h0);
    for (int i = 1; i <= 10; i++)
      push(0, 1, 0, 0, 32'(i), 0, 0, 1, 0, 32'h0, 32'h0);
    push(0, 1, 0, 0, 32'd11, 1, 1, 1, 0, 32'd1, 32'd11);
    push(0, 0, 0, 0, 32'h0, 1, 0, 1, 0, 32'd1, 32'd11);
    push(0, 0, 0, 1, 32'h0, 0, 0, 1, 0, 32'h0, 32'h0);
    push(0, 0, 0, 1, 32'h0, 0, 0, 1, 0, 32'h0, 32'h0);
    // Scenario 3: partial block, abort together with a beat, then a clean block.
    for (int i = 0; i < 5; i++)
      push(0, 1, 0, 0, 32'hFFFF_FFFF, 0, 0, 1, 0, 32'h0, 32'h0);
    push(0, 1, 1, 0, 32'hFFFF_FFFF, 0, 0, 1, 0, 32'h0, 32'h0);
    for (int i = 0; i < 10; i++)
      push(0, 1, 0, 0, 32'h1234_5678, 0, 0, 1, 0, 32'h0, 32'h0);
    push(0, 1, 0, 0, 32'h1234_5678, 1, 1, 1, 0, 32'h1234_5678, 32'h1234_5678);
    push(0, 0, 0, 0, 32'h0, 1, 0, 1, 0, 32'h1234_5678, 32'h1234_5678);
    push(0, 0, 0, 1, 32'h0, 0, 0, 1, 0, 32'h0, 32'h0);

    for (int k = 0; k < tbl.size(); k++) begin
      drive(tbl[k].r, tbl[k].wv, tbl[k].d, tbl[k].ab, tbl[k].rc);
      chk1($sformatf("v%0d/validOut", k), bus.validOut, tbl[k].ev);
      chk1($sformatf("v%0d/newBlock", k), bus.newBlock, tbl[k].en);
      chk1($sformatf("v%0d/writeReady", k), bus.writeReady, tbl[k].er);
      chk1($sformatf("v%0d/overflow", k), bus.overflow, tbl[k].eo);
      chk32($sformatf("v%0d/init_top", k), bus.initialState[351:320], tbl[k].etop);
      chk32($sformatf("v%0d/init_bot", k), bus.initialState[31:0], tbl[k].ebot);
    end

    // Scenario 2: fill ring, drop a beat, drop again with same-cycle consume.
    a_blk = mk_blk(32'hAAAA_AAAA, 0);
    b_blk = mk_blk(32'h5555_5555, 0);
    c_blk = mk_blk(32'h0C0C_0C00, 1);
    send(32'hAAAA_AAAA, 0, BEATS);
    chk_out("s2_a_done", 1, 1, 1, 0, a_blk);
    send(32'h5555_5555, 0, BEATS);
    chk_out("s2_full", 1, 0, 0, 0, a_blk);
    drive(0, 1, 32'hDEAD_0001, 0, 0);
    chk_out("s2_drop", 1, 0, 0, 1, a_blk);
    drive(0, 1, 32'hDEAD_0002, 0, 1);
    chk_out("s2_drop_consume", 1, 1, 1, 1, b_blk);
    send(32'h0C0C_0C00, 1, BEATS);
    chk_out("s2_c_stored", 1, 0, 0, 1, b_blk);
    drive(0, 0, 32'h0, 0, 1);
    chk_out("s2_head_c", 1, 1, 1, 1, c_blk);
    drive(0, 0, 32'h0, 0, 1);
    chk_out("s2_empty", 0, 0, 1, 1, '0);

    // Scenario 4: final beat of block 2 coincides with consume of block 1.
    a_blk = mk_blk(32'hA000_0000, 1);
    b_blk = mk_blk(32'hB000_0000, 1);
    send(32'hA000_0000, 1, BEATS);
    chk_out("s4_a", 1, 1, 1, 1, a_blk);
    idle();
    chk_out("s4_a_hold", 1, 0, 1, 1, a_blk);
    send(32'hB000_0000, 1, BEATS - 1);
    drive(0, 1, 32'hB000_000A, 0, 1);
    chk_out("s4_swap", 1, 1, 1, 1, b_blk);
    idle();
    chk_out("s4_b_hold", 1, 0, 1, 1, b_blk);
    drive(0, 0, 32'h0, 0, 1);
    chk_out("s4_empty", 0, 0, 1, 1, '0);

    // Scenario 5: reset mid-block with one block stored, then a fresh block.
    send(32'h5000_0000, 1, BEATS);
    send(32'h5100_0000, 1, 6);
    drive(1, 1, 32'h5100_0006, 0, 0);
    chk_out("s5_reset", 0, 0, 1, 0, '0);
`ifdef BLKSTORE_CNT_EN
    chk32("s5_cnt_reset", bus.blockCount, 32'd0);
`endif
    send(32'h0000_0001, 1, BEATS);
    chk_out("s5_fresh", 1, 1, 1, 0, mk_blk(32'h0000_0001, 1));
`ifdef BLKSTORE_CNT_EN
    chk32("s5_cnt_one", bus.blockCount, 32'd1);
`endif

    // Scenario 6: five completed blocks plus one abort and one dropped beat.
    drive(1, 0, 32'h0, 0, 0);
    chk_out("s6_reset", 0, 0, 1, 0, '0);
    send(32'h6100_0000, 1, BEATS);
    send(32'h6200_0000, 1, BEATS);
    drive(0, 1, 32'hDEAD_0003, 0, 0);
    drive(0, 0, 32'h0, 0, 1);
    drive(0, 0, 32'h0, 0, 1);
    send(32'h6300_0000, 1, 3);
    drive(0, 0, 32'h0, 1, 0);
    send(32'h6400_0000, 1, BEATS);
    drive(0, 0, 32'h0, 0, 1);
    send(32'h6500_0000, 1, BEATS);
    send(32'h6600_0000, 1, BEATS);
    chk_out("s6_final", 1, 0, 0, 1, mk_blk(32'h6500_0000, 1));
`ifdef BLKSTORE_CNT_EN
    chk32("s6_cnt", bus.blockCount, 32'd5);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
